// File: rtl/lcd_score_sequencer.sv
// Feeds the LCD byte writer: power-on delay, HD44780 init list, then
// "P1:a P2:b" at DDRAM 0x00 on every score update request.
module lcd_score_sequencer #(
   parameter int unsigned POWER_ON_CYCLES = 750000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [3:0] ScoreA,
   input  logic [3:0] ScoreB,
   input  logic       Update,
   output logic       Busy,
   output logic       InitDone,
   output logic       LcdStart,
   output logic       LcdRS,
   output logic [7:0] LcdData,
   input  logic       LcdDone,
   output logic [2:0] DebugState
);

   // Handshake with the writer: LcdStart pulses for one cycle with LcdRS/LcdData
   // valid; both stay stable until the writer's LcdDone pulse ends the transfer.
   // A Done still high from the previous byte is ignored (WAIT_LOW).

   typedef enum logic [2:0] {
      POWER_WAIT = 3'd0,
      ISSUE      = 3'd1,
      WAIT_LOW   = 3'd2,
      WAIT_HIGH  = 3'd3,
      IDLE       = 3'd4
   } state_t;

   localparam int CW = (POWER_ON_CYCLES > 1) ? $clog2(POWER_ON_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(POWER_ON_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [3:0]    idx;
   logic          pending;
   logic [3:0]    score_a_q;
   logic [3:0]    score_b_q;

   logic          launch;
   logic [3:0]    launch_idx;
   logic          redraw;

   function automatic logic [7:0] digit(input logic [3:0] s);
      return (s > 4'd9) ? 8'h39 : (8'h30 + {4'd0, s});
   endfunction

   function automatic logic [8:0] entry(input logic [3:0] i,
                                        input logic [3:0] sa,
                                        input logic [3:0] sb);
      case (i)
         4'd0:    return {1'b0, 8'h38};
         4'd1:    return {1'b0, 8'h0C};
         4'd2:    return {1'b0, 8'h06};
         4'd3:    return {1'b0, 8'h01};
         4'd4:    return {1'b0, 8'h80};
         4'd5:    return {1'b1, 8'h50};
         4'd6:    return {1'b1, 8'h31};
         4'd7:    return {1'b1, 8'h3A};
         4'd8:    return {1'b1, digit(sa)};
         4'd9:    return {1'b1, 8'h20};
         4'd10:   return {1'b1, 8'h50};
         4'd11:   return {1'b1, 8'h32};
         4'd12:   return {1'b1, 8'h3A};
         4'd13:   return {1'b1, digit(sb)};
         default: return {1'b0, 8'h00};
      endcase
   endfunction

   // Decide whether the next cycle is an ISSUE, and for which list entry.
   always_comb begin
      launch     = 1'b0;
      launch_idx = idx;
      redraw     = 1'b0;
      case (state)
         POWER_WAIT: begin
            if (cnt == CNT_LAST) begin
               launch     = 1'b1;
               launch_idx = 4'd0;
            end
         end
         WAIT_HIGH: begin
            if (LcdDone) begin
               if (idx == 4'd3 || idx == 4'd13) begin
                  if (pending) begin
                     launch     = 1'b1;
                     launch_idx = 4'd4;
                     redraw     = 1'b1;
                  end
               end else begin
                  launch     = 1'b1;
                  launch_idx = idx + 4'd1;
               end
            end
         end
         IDLE: begin
            if (Update || pending) begin
               launch     = 1'b1;
               launch_idx = 4'd4;
               redraw     = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state     <= POWER_WAIT;
         cnt       <= '0;
         idx       <= 4'd0;
         pending   <= 1'b0;
         score_a_q <= 4'd0;
         score_b_q <= 4'd0;
         InitDone  <= 1'b0;
         LcdStart  <= 1'b0;
         LcdRS     <= 1'b0;
         LcdData   <= 8'h00;
      end else begin
         if (redraw) begin
            score_a_q <= ScoreA;
            score_b_q <= ScoreB;
            pending   <= 1'b0;
         end else if (Update && state != IDLE) begin
            pending <= 1'b1;
         end

         if (state == WAIT_HIGH && LcdDone && idx == 4'd3)
            InitDone <= 1'b1;

         LcdStart <= launch;
         if (launch) begin
            // Message bytes read the snapshot, never the live score inputs.
            {LcdRS, LcdData} <= entry(launch_idx, score_a_q, score_b_q);
            idx   <= launch_idx;
            state <= ISSUE;
         end else begin
            case (state)
               POWER_WAIT: cnt   <= cnt + 1'b1;
               ISSUE:      state <= WAIT_LOW;
               WAIT_LOW:   if (!LcdDone) state <= WAIT_HIGH;
               WAIT_HIGH:  if (LcdDone) state <= IDLE;
               default:    state <= state;
            endcase
         end
      end
   end

   assign Busy       = (state != IDLE) || pending;
   assign DebugState = state;

endmodule

// File: tb/tb_lcd_score_sequencer.sv
// Directed bench for lcd_score_sequencer with a behavioural LCD writer model.
module tb_lcd_score_sequencer;

   logic       clk;
   logic       rst;
   logic [3:0] score_a;
   logic [3:0] score_b;
   logic       update;
   logic       busy;
   logic       init_done;
   logic       lcd_start;
   logic       lcd_rs;
   logic [7:0] lcd_data;
   logic       lcd_done;
   logic [2:0] dbg_state;

   int vec_cnt = 0;
   int err_cnt = 0;
   int done_len = 1;

   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];

   lcd_score_sequencer #(.POWER_ON_CYCLES(10)) dut (
      .Clock(clk), .Reset(rst), .ScoreA(score_a), .ScoreB(score_b),
      .Update(update), .Busy(busy), .InitDone(init_done),
      .LcdStart(lcd_start), .LcdRS(lcd_rs), .LcdData(lcd_data),
      .LcdDone(lcd_done), .DebugState(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      assert (got === exp) else begin
         err_cnt++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // writer model: Done rises 5 cycles after Start, held done_len cycles
   initial begin
      int delay_cnt;
      int hold_cnt;
      delay_cnt = 0;
      hold_cnt  = 0;
      lcd_done  = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            delay_cnt = 0;
            hold_cnt  = 0;
            lcd_done  = 1'b0;
         end else begin
            if (hold_cnt > 0) begin
               hold_cnt--;
               if (hold_cnt == 0) lcd_done = 1'b0;
            end
            if (delay_cnt > 0) begin
               delay_cnt--;
               if (delay_cnt == 0) begin
                  lcd_done = 1'b1;
                  hold_cnt = done_len;
               end
            end
            if (lcd_start) delay_cnt = 5;
         end
      end
   end

   // monitor: record each started byte, check it is held until its Done
   initial begin
      logic       open;
      logic       seen_low;
      logic [8:0] cur;
      open = 1'b0;
      seen_low = 1'b0;
      cur = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            open = 1'b0;
         end else if (lcd_start) begin
            check("start_while_waiting", {31'd0, open}, 32'd0);
            cur = {lcd_rs, lcd_data};
            obs_q.push_back(cur);
            open = 1'b1;
            seen_low = 1'b0;
         end else if (open) begin
            check("hold_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, cur});
            if (!lcd_done) seen_low = 1'b1;
            else if (seen_low) open = 1'b0;
         end
      end
   end

   // driver tasks
   task automatic pulse_update();
      @(negedge clk);
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < budget);
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   task automatic push_init();
      exp_q.push_back({1'b0, 8'h38});
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b0, 8'h06});
      exp_q.push_back({1'b0, 8'h01});
   endtask

   task automatic push_line(input logic [7:0] da, input logic [7:0] db);
      exp_q.push_back({1'b0, 8'h80});
      exp_q.push_back({1'b1, 8'h50});
      exp_q.push_back({1'b1, 8'h31});
      exp_q.push_back({1'b1, 8'h3A});
      exp_q.push_back({1'b1, da});
      exp_q.push_back({1'b1, 8'h20});
      exp_q.push_back({1'b1, 8'h50});
      exp_q.push_back({1'b1, 8'h32});
      exp_q.push_back({1'b1, 8'h3A});
      exp_q.push_back({1'b1, db});
   endtask

   // scoreboard: compare observed transfers against the expected queue
   task automatic check_xfers(input string tag);
      int n;
      check({tag, "_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_byte%0d", tag, i), {23'd0, obs_q[i]}, {23'd0, exp_q[i]});
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1;
      score_a = 4'd0;
      score_b = 4'd0;
      update = 1'b0;
      #3;
      check("rst_start", {31'd0, lcd_start}, 32'd0);
      check("rst_rs", {31'd0, lcd_rs}, 32'd0);
      check("rst_data", {24'd0, lcd_data}, 32'd0);
      check("rst_initdone", {31'd0, init_done}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd1);

      // power-on delay of 10 cycles, then the init list
      @(negedge clk);
      rst = 1'b0;
      repeat (9) @(negedge clk);
      check("pwr_no_start_yet", {31'd0, lcd_start}, 32'd0);
      @(negedge clk);
      check("pwr_first_start", {31'd0, lcd_start}, 32'd1);
      check("pwr_first_byte", {23'd0, lcd_rs, lcd_data}, {23'd0, 9'h038});
      wait_idle("init_idle", 500);
      push_init();
      check_xfers("init");
      check("init_done", {31'd0, init_done}, 32'd1);
      repeat (20) @(negedge clk);
      check("init_quiet", obs_q.size(), 0);

      // redraw with 3 and 7, including request-to-start latency
      score_a = 4'd3;
      score_b = 4'd7;
      @(negedge clk);
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      check("lat_start", {31'd0, lcd_start}, 32'd1);
      check("lat_byte", {23'd0, lcd_rs, lcd_data}, {23'd0, 9'h080});
      wait_idle("redraw_idle", 500);
      push_line(8'h33, 8'h37);
      check_xfers("redraw37");

      // request during power-on wait, scores clamp to '9'
      @(negedge clk);
      rst = 1'b1;
      score_a = 4'd12;
      score_b = 4'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      obs_q.delete();
      repeat (3) @(negedge clk);
      check("pwr_busy", {31'd0, busy}, 32'd1);
      pulse_update();
      wait_idle("pend_idle", 1000);
      push_init();
      push_line(8'h39, 8'h30);
      check_xfers("pend_redraw");

      // several requests mid-redraw collapse into one more redraw
      score_a = 4'd1;
      score_b = 4'd5;
      pulse_update();
      repeat (8) @(negedge clk);
      pulse_update();
      score_a = 4'd2;
      repeat (2) @(negedge clk);
      pulse_update();
      repeat (2) @(negedge clk);
      pulse_update();
      wait_idle("multi_idle", 1000);
      push_line(8'h31, 8'h35);
      push_line(8'h32, 8'h35);
      check_xfers("multi");

      // reset while waiting on transfer 6
      pulse_update();
      begin
         int n;
         n = 0;
         while (obs_q.size() < 3 && n < 200) begin
            @(negedge clk);
            n++;
         end
         check("reach_xfer6", obs_q.size(), 3);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_start", {31'd0, lcd_start}, 32'd0);
      check("midrst_rs", {31'd0, lcd_rs}, 32'd0);
      check("midrst_data", {24'd0, lcd_data}, 32'd0);
      check("midrst_initdone", {31'd0, init_done}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd1);
      exp_q.push_back({1'b0, 8'h80});
      exp_q.push_back({1'b1, 8'h50});
      exp_q.push_back({1'b1, 8'h31});
      check_xfers("pre_rst");
      @(negedge clk);
      rst = 1'b0;
      repeat (9) @(negedge clk);
      check("rerst_no_start_yet", {31'd0, lcd_start}, 32'd0);
      repeat (10) @(negedge clk);
      check("rerst_initdone_low", {31'd0, init_done}, 32'd0);
      wait_idle("rerst_idle", 500);
      push_init();
      check_xfers("rerst_init");
      check("rerst_initdone", {31'd0, init_done}, 32'd1);

      // Done held for 3 cycles: no double issue, data held
      done_len = 3;
      score_a = 4'd9;
      score_b = 4'd15;
      pulse_update();
      wait_idle("longdone_idle", 1000);
      push_line(8'h39, 8'h39);
      check_xfers("longdone");
      repeat (10) @(negedge clk);
      check("longdone_quiet", obs_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/lcd_score_sequencer.md
Name: lcd_score_sequencer

Overview:
- Upstream feeder for the LCD byte-writer custom-instruction block in the pong system.
- After reset it runs the HD44780 power-on delay and init command list, then on each score update request it writes the line "P1:a P2:b" at DDRAM address 0x00.
- Each byte goes out over the writer's Start/Done handshake: LcdRS drives the writer's DataA[0] and LcdData drives its DataB[7:0]. The writer's ClockEnable is tied high at top level.

Parameters:
POWER_ON_CYCLES, 750000, Clock cycles waited after reset release before the first command (15 ms at 50 MHz); legal range is 1 or more.

Ports:
Clock  input  1  system clock, all logic on the rising edge
Reset  input  1  asynchronous, active-high reset
ScoreA  input  4  player 1 score, binary
ScoreB  input  4  player 2 score, binary
Update  input  1  one-cycle request to redraw the score line
Busy  output  1  high while the power-on delay, init or a redraw is running, or while a request is pending
InitDone  output  1  high once the init list has completed; stays high until reset
LcdStart  output  1  one-cycle start strobe to the LCD writer
LcdRS  output  1  register select for the current byte (0 = command, 1 = data)
LcdData  output  8  byte for the current transfer
LcdDone  input  1  completion pulse from the LCD writer

Behaviour:
- Reset (async, active-high) values:
  - LcdStart=0, LcdRS=0, LcdData=0x00, InitDone=0, Busy=1.
  - Pending flag clears, delay counter clears, FSM goes to POWER_WAIT.
  - Reset asserted mid-transfer aborts the transfer; the whole sequence, including the power-on delay, restarts on release.
- FSM states: POWER_WAIT, ISSUE, WAIT_LOW, WAIT_HIGH, IDLE.
- POWER_WAIT:
  - Counter increments every cycle.
  - When it reaches POWER_ON_CYCLES-1, index=0 and the FSM goes to ISSUE.
- Transfer list, indexed 0..13:
  - Init, RS=0: 0x38, 0x0C, 0x06, 0x01 (indices 0..3).
  - Message command, RS=0: 0x80 (index 4).
  - Message data, RS=1: 0x50, 0x31, 0x3A, dA, 0x20, 0x50, 0x32, 0x3A, dB (indices 5..13).
  - dA = 0x30 + min(ScoreA, 9); dB = 0x30 + min(ScoreB, 9). Scores 10..15 display as '9'.
- Score snapshot: ScoreA and ScoreB are registered when a redraw starts (transition into index 4). Score changes during the redraw do not affect the bytes sent.
- ISSUE (one cycle):
  - LcdRS and LcdData are loaded from the list entry at the current index.
  - LcdStart=1 for exactly this cycle.
  - Next state is WAIT_LOW.
- Hold rule: LcdRS and LcdData stay stable from ISSUE until the LcdDone that ends the transfer.
- WAIT_LOW: waits until LcdDone=0. This ignores a stale Done pulse left over from the previous transfer.
- WAIT_HIGH: on LcdDone=1 the current byte is complete.
  - If index=3: InitDone<=1. If pending=1, index=4 and go to ISSUE; otherwise go to IDLE.
  - If index=13: redraw done. If pending=1, index=4 and go to ISSUE; otherwise go to IDLE.
  - Otherwise: index+1 and go to ISSUE.
- Pending flag:
  - Update=1 in any state other than IDLE sets pending.
  - Pending clears when a redraw starts (index set to 4).
  - Multiple requests arriving during one redraw collapse into a single further redraw.
- IDLE: Update=1 starts a redraw (index=4, go to ISSUE) in the next cycle.
- Update asserted on the same cycle a redraw completes sets pending, so exactly one more redraw follows.
- Busy = (state != IDLE) | pending. Busy is 0 only in IDLE with nothing pending.
- LcdStart is never asserted in POWER_WAIT, WAIT_LOW, WAIT_HIGH or IDLE.
- Latency, IDLE with Update=1 at cycle t: LcdStart=1 at cycle t+1 with LcdRS=0, LcdData=0x80.
- No timeout on LcdDone. The block waits indefinitely; reset is the only escape.

Test Plan:
- Bench setup for all scenarios: POWER_ON_CYCLES=10; behavioural writer model returns LcdDone 5 cycles after Start, pulsed 1 cycle.
- Reset release, no Update -> after 10 cycles, 4 transfers RS=0 in order 0x38, 0x0C, 0x06, 0x01. Then InitDone=1, Busy=0, and no further LcdStart.
- After init, ScoreA=3, ScoreB=7, Update pulse -> 10 transfers: 0x80 (RS=0), then 0x50 0x31 0x3A 0x33 0x20 0x50 0x32 0x3A 0x37 (RS=1). Busy returns to 0.
- Update pulse during POWER_WAIT with ScoreA=12, ScoreB=0 -> init list, then one redraw with dA=0x39, dB=0x30, then IDLE.
- Three Update pulses during a redraw, with ScoreA changed from 1 to 2 mid-redraw -> current redraw still sends 0x31, then exactly one more redraw sends 0x32.
- Reset pulsed while waiting on transfer 6 -> outputs immediately go to reset values. After release, the 10-cycle delay and the full init list repeat, with InitDone=0 until init completes.
- Writer model holds LcdDone=1 for 3 cycles -> each byte is issued exactly once, LcdStart is never asserted while the FSM is waiting, and data stays stable until completion.
